// File: rtl/logs_iterate_engine_pkg.sv
// logs_pkg: shared types and constants for the multi-channel iterate engine.
//   - logs_state_e : controller state encoding
//   - LOGS_MODE_*  : map selection values for the mode input
//   - initial_x()  : reset value of every channel's x for a given FRAC
package logs_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP1,
        MUL1,
        SETUP2,
        MUL2,
        WRITE,
        OUT
    } logs_state_e;

    localparam logic LOGS_MODE_LOGISTIC = 1'b0;
    localparam logic LOGS_MODE_TENT     = 1'b1;

    // x resets to 1/16 so a freshly reset channel is not stuck at the fixed point 0.
    function automatic int unsigned initial_x(input int unsigned frac);
        return 32'd1 << (frac - 4);
    endfunction

endpackage

// File: rtl/logs_iterate_engine_if.sv
// logs_out_if: valid/ready stream carrying one new iterate per transfer.
//   out_valid : iterate available (producer)
//   out_ready : consumer accepts (consumer)
//   out_ch    : channel index of the iterate (producer)
//   out_x     : new x value, 0.FRAC format (producer)
interface logs_out_if #(
    parameter int FRAC = 8,
    parameter int CH_W = 2
);
    logic            out_valid;
    logic            out_ready;
    logic [CH_W-1:0] out_ch;
    logic [FRAC-1:0] out_x;

    modport master (output out_valid, output out_ch, output out_x, input out_ready);
    modport slave  (input out_valid, input out_ch, input out_x, output out_ready);
endinterface

// File: rtl/logs_iterate_engine_shift_mult.sv
// logs_shift_mult: serial shift-and-add multiplier, one multiplier bit per step.
//   load  : capture m1_in/m2_in and clear the accumulator
//   step  : if m2[0] acc += m1; m1 <<= 1; m2 >>= 1
//   acc   : 2*FRAC+2-bit product, valid after FRAC steps
module logs_shift_mult #(
    parameter int FRAC = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [FRAC+1:0]   m1_in,
    input  logic [FRAC-1:0]   m2_in,
    output logic [2*FRAC+1:0] acc
);
    logic [2*FRAC+1:0] m1_reg;
    logic [FRAC-1:0]   m2_reg;
    logic [2*FRAC+1:0] acc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1_reg  <= '0;
            m2_reg  <= '0;
            acc_reg <= '0;
        end else if (load) begin
            m1_reg  <= {{FRAC{1'b0}}, m1_in};
            m2_reg  <= m2_in;
            acc_reg <= '0;
        end else if (step) begin
            if (m2_reg[0]) begin
                acc_reg <= acc_reg + m1_reg;
            end
            m1_reg <= m1_reg << 1;
            m2_reg <= m2_reg >> 1;
        end
    end

    assign acc = acc_reg;

endmodule

// File: rtl/logs_iterate_engine.sv
// logs_iterate_engine: multi-channel logistic / tent map iterator.
// Holds per-channel r (2.FRAC) and x (0.FRAC); each pass updates every
// channel in order with one shared serial multiplier and streams the new x.
//   clk, rst_n          : clock, asynchronous active-low reset
//   cfg_we/ch/r/x0      : per-channel config write (IDLE only)
//   mode, iters, start  : run control, sampled when start is accepted
//   halt                : abort to IDLE without done
//   busy, done          : run status; done is a one-cycle pulse
//   out_if              : iterate stream (valid/ready, channel, x)
module logs_iterate_engine
    import logs_pkg::*;
#(
    parameter int FRAC     = 8,
    parameter int CHANNELS = 4,
    parameter int ITER_W   = 8,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [FRAC+1:0]   cfg_r,
    input  logic [FRAC-1:0]   cfg_x0,
    input  logic              mode,
    input  logic [ITER_W-1:0] iters,
    input  logic              start,
    input  logic              halt,
    output logic              busy,
    output logic              done,
    logs_out_if.master        out_if
);
    localparam logic [FRAC-1:0] X_RST = FRAC'(initial_x(FRAC));
    localparam int              CNT_W = $clog2(FRAC);

    logs_state_e state_reg, state_next;

    logic [FRAC-1:0]   x_mem [CHANNELS];
    logic [FRAC+1:0]   r_mem [CHANNELS];
    logic [CH_W-1:0]   ch_reg;
    logic [ITER_W-1:0] pass_reg;
    logic              mode_reg;
    logic [FRAC-1:0]   q_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [FRAC-1:0]   out_x_reg;
    logic [CH_W-1:0]   out_ch_reg;
    logic              done_reg;

    logic              mult_load, mult_step, x_wr, hs, done_next, start_ok, cfg_wr;
    logic [FRAC+1:0]   mult_m1;
    logic [FRAC-1:0]   mult_m2;
    logic [2*FRAC+1:0] acc;
    logic [FRAC-1:0]   x_cur, x_inv, tent_q, result;
    logic [FRAC+1:0]   r_cur;
    logic              ch_last, last_step;
    logic [CHANNELS-1:0] cfg_hit, wr_hit;
    logic              unused_acc_low;

    assign x_cur     = x_mem[ch_reg];
    assign r_cur     = r_mem[ch_reg];
    assign x_inv     = ~x_cur;
    assign tent_q    = (x_cur < x_inv) ? x_cur : x_inv;
    assign ch_last   = (ch_reg == CH_W'(CHANNELS - 1));
    assign last_step = (cnt_reg == CNT_W'(FRAC - 1));
    // Integer bits of the 2.2FRAC product set means r*q >= 1: clamp.
    assign result    = (|acc[2*FRAC+1:2*FRAC]) ? '1 : acc[2*FRAC-1:FRAC];
    assign unused_acc_low = ^acc[FRAC-1:0];

    assign start_ok = (state_reg == IDLE) && start && (iters != '0);
    assign cfg_wr   = (state_reg == IDLE) && cfg_we
                      && ({1'b0, cfg_ch} < (CH_W + 1)'(CHANNELS));

    // First multiply is x*(1-x); second is r*q, where q comes from the
    // accumulator (logistic) or from the min(x,1-x) captured in SETUP1 (tent).
    assign mult_m1 = (state_reg == SETUP1) ? {2'b00, x_cur} : r_cur;
    assign mult_m2 = (state_reg == SETUP1)       ? x_inv :
                     (mode_reg == LOGS_MODE_TENT) ? q_reg : acc[2*FRAC-1:FRAC];

    logs_shift_mult #(.FRAC(FRAC)) u_mult (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (mult_load),
        .step  (mult_step),
        .m1_in (mult_m1),
        .m2_in (mult_m2),
        .acc   (acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        mult_load  = 1'b0;
        mult_step  = 1'b0;
        x_wr       = 1'b0;
        hs         = 1'b0;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (iters == '0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = SETUP1;
                    end
                end
            end
            SETUP1: begin
                if (mode_reg == LOGS_MODE_LOGISTIC) begin
                    mult_load  = 1'b1;
                    state_next = MUL1;
                end else begin
                    state_next = SETUP2;
                end
            end
            MUL1: begin
                mult_step = 1'b1;
                if (last_step) begin
                    state_next = SETUP2;
                end
            end
            SETUP2: begin
                mult_load  = 1'b1;
                state_next = MUL2;
            end
            MUL2: begin
                mult_step = 1'b1;
                if (last_step) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                x_wr       = 1'b1;
                state_next = OUT;
            end
            OUT: begin
                if (out_if.out_ready) begin
                    hs         = 1'b1;
                    state_next = SETUP1;
                    if (ch_last && (pass_reg == ITER_W'(1))) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // Abort overrides everything, including a same-cycle handshake.
        if (halt && (state_reg != IDLE)) begin
            state_next = IDLE;
            mult_load  = 1'b0;
            mult_step  = 1'b0;
            x_wr       = 1'b0;
            hs         = 1'b0;
            done_next  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_reg     <= '0;
            pass_reg   <= '0;
            mode_reg   <= LOGS_MODE_LOGISTIC;
            q_reg      <= '0;
            cnt_reg    <= '0;
            out_x_reg  <= '0;
            out_ch_reg <= '0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= done_next;
            if (start_ok) begin
                mode_reg <= mode;
                pass_reg <= iters;
                ch_reg   <= '0;
            end
            if (state_reg == SETUP1) begin
                q_reg <= tent_q;
            end
            if (mult_load) begin
                cnt_reg <= '0;
            end else if (mult_step) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (x_wr) begin
                out_x_reg  <= result;
                out_ch_reg <= ch_reg;
            end
            if (hs) begin
                if (ch_last) begin
                    ch_reg   <= '0;
                    pass_reg <= pass_reg - 1'b1;
                end else begin
                    ch_reg <= ch_reg + 1'b1;
                end
            end
        end
    end

    // Per-channel write strobes: config port (IDLE) and iterate write-back (WRITE).
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch_hit
        assign cfg_hit[gi] = cfg_wr && (cfg_ch == CH_W'(gi));
        assign wr_hit[gi]  = x_wr && (ch_reg == CH_W'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                x_mem[c] <= X_RST;
                r_mem[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (cfg_hit[c]) begin
                    r_mem[c] <= cfg_r;
                    x_mem[c] <= cfg_x0;
                end else if (wr_hit[c]) begin
                    x_mem[c] <= result;
                end
            end
        end
    end

    assign busy             = (state_reg != IDLE);
    assign done             = done_reg;
    assign out_if.out_valid = (state_reg == OUT);
    assign out_if.out_ch    = out_ch_reg;
    assign out_if.out_x     = out_x_reg;

endmodule
